// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, req/ready imem handshake and IF/ID register; `IF_STALL_CNT_EN adds stall_cycles.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction,
  output logic        valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic [31:0] hold_pc;
  logic [31:0] drain_addr;
  assign imem_req  = !rst && state != HOLD;
  // a redirected request must keep its original address until the memory takes it
  assign imem_addr = state == DRAIN ? drain_addr : pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      PC_out      <= '0;
      instruction <= '0;
      valid       <= 1'b0;
      hold_word   <= '0;
      hold_pc     <= '0;
      drain_addr  <= '0;
    end else if (branch_taken) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= branch_addr;
      state       <= (state == FETCH || state == DRAIN) && !imem_ready ? DRAIN : FETCH;
      if (state == FETCH) drain_addr <= pc;
    end else if (state == HOLD) begin
      if (!freeze) begin
        PC_out      <= hold_pc;
        instruction <= hold_word;
        valid       <= 1'b1;
        pc          <= pc + 32'd4;
        state       <= FETCH;
      end
    end else if (state == DRAIN) begin
      valid       <= 1'b0;
      instruction <= '0;
      if (imem_ready) state <= FETCH;
    end else if (freeze) begin
      if (imem_ready) begin
        hold_word <= imem_rdata;
        hold_pc   <= pc + 32'd4;
        state     <= HOLD;
      end
    end else if (imem_ready) begin
      instruction <= imem_rdata;
      PC_out      <= pc + 32'd4;
      valid       <= 1'b1;
      pc          <= pc + 32'd4;
    end else begin
      valid       <= 1'b0;
      instruction <= '0;
    end
  end
`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (freeze && !branch_taken) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage against a combinational zero/variable-wait instruction memory.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ready;
  logic [31:0] branch_addr, imem_rdata, imem_addr, PC_out, instruction;
  logic        imem_req, valid;
  int          vectors = 0;
  int          miscompares = 0;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_out(PC_out),
    .instruction(instruction), .valid(valid)
`ifdef IF_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction
  assign imem_rdata = w(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pco);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, "_instr"}, instruction, ins);
    chk({tag, "_pcout"}, PC_out, pco);
  endtask
  task automatic bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_instr"}, instruction, 32'd0);
  endtask
  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    out("rst", 1'b0, 32'd0, 32'd0);
`ifdef IF_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    rst = 1'b0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    tick(); out("f0", 1'b1, w(0), 32'd4);
    imem_ready = 1'b0;
    tick(); bubble("wait1");
    chk("wait_addr", imem_addr, 32'd4);
    tick(); bubble("wait2");
    imem_ready = 1'b1;
    tick(); out("f4", 1'b1, w(4), 32'd8);
    freeze = 1'b1;
    tick(); out("frz1", 1'b1, w(4), 32'd8);
    chk("hold_req1", {31'd0, imem_req}, 32'd0);
    tick(); out("frz2", 1'b1, w(4), 32'd8);
    tick(); out("frz3", 1'b1, w(4), 32'd8);
    chk("hold_req3", {31'd0, imem_req}, 32'd0);
    freeze = 1'b0;
    tick(); out("f8", 1'b1, w(8), 32'd12);
    chk("resume_addr", imem_addr, 32'd12);
`ifdef IF_STALL_CNT_EN
    chk("stall3", stall_cycles, 32'd3);
`endif
    for (int a = 12; a < 32; a += 4) begin
      tick(); out("run", 1'b1, w(a), a + 4);
    end
    chk("pre_br_addr", imem_addr, 32'h20);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    tick(); bubble("br");
    branch_taken = 1'b0; #1;
    chk("drain_addr1", imem_addr, 32'h20);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    tick(); bubble("drain");
    chk("drain_addr2", imem_addr, 32'h20);
    imem_ready = 1'b1;
    tick(); bubble("drain_done");
    chk("target_addr", imem_addr, 32'h100);
    tick(); out("t100", 1'b1, w(32'h100), 32'h104);
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
    tick(); bubble("br_frz");
    freeze = 1'b0; branch_taken = 1'b0; #1;
    chk("br_frz_addr", imem_addr, 32'h200);
`ifdef IF_STALL_CNT_EN
    chk("stall_brfrz", stall_cycles, 32'd3);
`endif
    tick(); out("t200", 1'b1, w(32'h200), 32'h204);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick(); bubble("br_wrap");
    branch_taken = 1'b0;
    tick(); out("wrap", 1'b1, w(32'hFFFF_FFFC), 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h300;
    tick(); bubble("br300");
    branch_taken = 1'b0; rst = 1'b1; #1;
    chk("rst_drain_req", {31'd0, imem_req}, 32'd0);
    tick(); out("rst2", 1'b0, 32'd0, 32'd0);
`ifdef IF_STALL_CNT_EN
    chk("rst2_stall", stall_cycles, 32'd0);
`endif
    rst = 1'b0; imem_ready = 1'b1; #1;
    chk("restart_addr", imem_addr, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    tick(); out("restart", 1'b1, w(0), 32'd4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
